// File: rtl/game_state_ctrl_pkg.sv
// Shared types and constants for the game sequencer and its neighbours.
package game_state_ctrl_pkg;

    // Encoding is visible to the renderers through game_active.
    typedef enum logic [1:0] {
        MENU = 2'd0,
        PLAY = 2'd1,
        LOST = 2'd2,
        WON  = 2'd3
    } game_state_t;

    localparam logic [3:0] MAX_HP = 4'd15;

    // Active video area of the display timing.
    localparam int unsigned HOR_PIXELS = 1024;
    localparam int unsigned VER_PIXELS = 768;

endpackage

// File: rtl/game_state_ctrl_if.sv
// Bundle of the sequencer's gameplay inputs and status outputs.
interface game_state_ctrl_if;

    logic        frame_tick;
    logic [11:0] mouse_x;
    logic [11:0] mouse_y;
    logic        mouse_left;
    logic [1:0]  char_class;
    logic [3:0]  char_hp;
    logic        hit;
    logic [3:0]  hit_dmg;
    logic        boss_dead;
    logic [1:0]  game_active;
    logic        mouse_clicked;
    logic [3:0]  player_hp;
    logic        invuln;
    logic        class_clear;

    // Environment side: drives inputs, observes status.
    modport master (
        output frame_tick, mouse_x, mouse_y, mouse_left, char_class, char_hp,
               hit, hit_dmg, boss_dead,
        input  game_active, mouse_clicked, player_hp, invuln, class_clear
    );

    // Sequencer side.
    modport slave (
        input  frame_tick, mouse_x, mouse_y, mouse_left, char_class, char_hp,
               hit, hit_dmg, boss_dead,
        output game_active, mouse_clicked, player_hp, invuln, class_clear
    );

endinterface

// File: rtl/game_state_ctrl_click_edge_detect.sv
// Synchronises a raw button level and emits one registered pulse per press.
module click_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic [1:0] sync_q;
    logic       level_q;
    logic       prev_q;
    logic [2:0] fill_q;
    logic       armed_q;
    logic       pulse_q;

    // 2-FF synchroniser, retimed level, edge detect and pulse register.
    // The detector only arms once the pipeline holds real samples and the
    // button has been seen released, so a button held through reset does
    // not fire a click when reset drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= 3'b000;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            level_q <= sync_q[1];
            prev_q  <= level_q;
            fill_q  <= {fill_q[1:0], 1'b1};
            if (fill_q[2] && !level_q) begin
                armed_q <= 1'b1;
            end
            pulse_q <= armed_q & level_q & ~prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game sequencer: MENU -> PLAY -> LOST/WON -> MENU, player HP,
// invulnerability frames and the end-screen hold counter.
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int unsigned START_X       = (HOR_PIXELS - 250) / 2,
    parameter int unsigned START_Y       = (VER_PIXELS - 75) / 3,
    parameter int unsigned START_W       = 250,
    parameter int unsigned START_H       = 75,
    parameter int unsigned INVULN_FRAMES = 30,
    parameter int unsigned END_FRAMES    = 120
) (
    input logic              clk,
    input logic              rst,
    game_state_ctrl_if.slave bus
);

    localparam int unsigned InvW = $clog2(INVULN_FRAMES + 1);
    localparam int unsigned EndW = $clog2(END_FRAMES + 1);

    localparam logic [InvW-1:0] InvLoad = InvW'(INVULN_FRAMES);
    localparam logic [EndW-1:0] EndMax  = EndW'(END_FRAMES);

    game_state_t     state_q, state_d;
    logic [3:0]      hp_q, hp_d;
    logic [InvW-1:0] inv_q, inv_d;
    logic [EndW-1:0] end_q, end_d;
    logic            clear_q, clear_d;

    logic       clicked;
    logic       in_box;
    logic       hit_ok;
    logic [3:0] hp_next;

    click_edge_detect u_click (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.mouse_left),
        .pulse (clicked)
    );

    assign in_box = (32'(bus.mouse_x) >= START_X) && (32'(bus.mouse_x) < START_X + START_W) &&
                    (32'(bus.mouse_y) >= START_Y) && (32'(bus.mouse_y) < START_Y + START_H);

    // Saturating damage; a hit is only taken while not invulnerable.
    assign hp_next = (bus.hit_dmg >= hp_q) ? 4'd0 : hp_q - bus.hit_dmg;
    assign hit_ok  = bus.hit && (inv_q == '0);

    // Next-state logic for the FSM, HP datapath and both frame counters.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        inv_d   = inv_q;
        end_d   = end_q;
        clear_d = 1'b0;
        unique case (state_q)
            MENU: begin
                if (clicked && in_box && bus.char_class != 2'd0) begin
                    state_d = PLAY;
                    hp_d    = bus.char_hp;
                    inv_d   = '0;
                end
            end
            PLAY: begin
                if (bus.frame_tick && inv_q != '0) begin
                    inv_d = inv_q - InvW'(1);
                end
                // Loading on a hit overrides the same-cycle decrement.
                if (hit_ok) begin
                    hp_d  = hp_next;
                    inv_d = InvLoad;
                end
                // Boss death takes priority over a simultaneous lethal hit.
                if (bus.boss_dead) begin
                    state_d = WON;
                    end_d   = '0;
                end else if (hit_ok && hp_next == 4'd0) begin
                    state_d = LOST;
                    end_d   = '0;
                end
            end
            LOST, WON: begin
                if (bus.frame_tick && end_q != EndMax) begin
                    end_d = end_q + EndW'(1);
                end
                if (clicked && end_q == EndMax) begin
                    state_d = MENU;
                    hp_d    = 4'd0;
                    inv_d   = '0;
                    clear_d = 1'b1;
                end
            end
            default: state_d = MENU;
        endcase
    end

    // State register; reset aborts any game in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MENU;
            hp_q    <= 4'd0;
            inv_q   <= '0;
            end_q   <= '0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            inv_q   <= inv_d;
            end_q   <= end_d;
            clear_q <= clear_d;
        end
    end

    assign bus.game_active   = state_q;
    assign bus.player_hp     = hp_q;
    assign bus.invuln        = (inv_q != '0);
    assign bus.class_clear   = clear_q;
    assign bus.mouse_clicked = clicked;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed testbench for game_state_ctrl.
module tb_game_state_ctrl;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    game_state_ctrl_if bus ();

    game_state_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the button long enough for the click to reach the FSM.
    task automatic press();
        bus.mouse_left = 1'b1;
        repeat (5) step();
    endtask

    task automatic release_btn();
        bus.mouse_left = 1'b0;
        repeat (5) step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus.game_active !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected 0", bus.game_active);
        end
        tests_run++;
        if (bus.player_hp !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_hp: got %0d expected 0", bus.player_hp);
        end
        tests_run++;
        if (bus.invuln !== 1'b0 || bus.class_clear !== 1'b0 || bus.mouse_clicked !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b%b%b expected 000",
                     bus.invuln, bus.class_clear, bus.mouse_clicked);
        end
    endtask

    task automatic test_menu();
        bus.hit = 1'b1; bus.hit_dmg = 4'd3; bus.boss_dead = 1'b1;
        step();
        bus.hit = 1'b0; bus.boss_dead = 1'b0;
        step();
        tests_run++;
        if (bus.game_active !== 2'd0 || bus.player_hp !== 4'd0) begin
            tests_failed++;
            $display("FAIL menu_ignores_hit: got state %0d hp %0d expected 0 0",
                     bus.game_active, bus.player_hp);
        end
        bus.mouse_x = 12'd512; bus.mouse_y = 12'd256;
        bus.char_class = 2'd0; bus.char_hp = 4'd10;
        press();
        tests_run++;
        if (bus.game_active !== 2'd0) begin
            tests_failed++;
            $display("FAIL menu_no_class: got %0d expected 0", bus.game_active);
        end
        release_btn();
        bus.char_class = 2'd1;
        bus.mouse_x = 12'd637;
        press();
        tests_run++;
        if (bus.game_active !== 2'd0) begin
            tests_failed++;
            $display("FAIL menu_x_edge: got %0d expected 0", bus.game_active);
        end
        release_btn();
        bus.mouse_x = 12'd512; bus.mouse_y = 12'd230;
        press();
        tests_run++;
        if (bus.game_active !== 2'd0) begin
            tests_failed++;
            $display("FAIL menu_y_edge: got %0d expected 0", bus.game_active);
        end
        release_btn();
        bus.mouse_y = 12'd256;
        press();
        tests_run++;
        if (bus.game_active !== 2'd1 || bus.player_hp !== 4'd10 || bus.invuln !== 1'b0) begin
            tests_failed++;
            $display("FAIL menu_start: got state %0d hp %0d inv %b expected 1 10 0",
                     bus.game_active, bus.player_hp, bus.invuln);
        end
        release_btn();
    endtask

    task automatic test_hits();
        bus.hit = 1'b1; bus.hit_dmg = 4'd3;
        step();
        bus.hit = 1'b0;
        tests_run++;
        if (bus.player_hp !== 4'd7 || bus.invuln !== 1'b1) begin
            tests_failed++;
            $display("FAIL hit_first: got hp %0d inv %b expected 7 1", bus.player_hp, bus.invuln);
        end
        frames(5);
        bus.hit = 1'b1; bus.hit_dmg = 4'd5;
        step();
        bus.hit = 1'b0;
        tests_run++;
        if (bus.player_hp !== 4'd7) begin
            tests_failed++;
            $display("FAIL hit_dropped: got %0d expected 7", bus.player_hp);
        end
        frames(24);
        tests_run++;
        if (bus.invuln !== 1'b1) begin
            tests_failed++;
            $display("FAIL invuln_29: got %b expected 1", bus.invuln);
        end
        frames(1);
        tests_run++;
        if (bus.invuln !== 1'b0) begin
            tests_failed++;
            $display("FAIL invuln_30: got %b expected 0", bus.invuln);
        end
        bus.hit = 1'b1; bus.hit_dmg = 4'd9;
        step();
        bus.hit = 1'b0;
        tests_run++;
        if (bus.player_hp !== 4'd0 || bus.game_active !== 2'd2) begin
            tests_failed++;
            $display("FAIL hit_lethal: got hp %0d state %0d expected 0 2",
                     bus.player_hp, bus.game_active);
        end
    endtask

    task automatic test_end_screen();
        frames(50);
        press();
        tests_run++;
        if (bus.game_active !== 2'd2) begin
            tests_failed++;
            $display("FAIL lost_click_50: got %0d expected 2", bus.game_active);
        end
        release_btn();
        frames(69);
        press();
        tests_run++;
        if (bus.game_active !== 2'd2) begin
            tests_failed++;
            $display("FAIL lost_click_119: got %0d expected 2", bus.game_active);
        end
        release_btn();
        frames(1);
        press();
        tests_run++;
        if (bus.game_active !== 2'd0 || bus.class_clear !== 1'b1 || bus.player_hp !== 4'd0) begin
            tests_failed++;
            $display("FAIL lost_to_menu: got state %0d clr %b hp %0d expected 0 1 0",
                     bus.game_active, bus.class_clear, bus.player_hp);
        end
        step();
        tests_run++;
        if (bus.class_clear !== 1'b0 || bus.invuln !== 1'b0) begin
            tests_failed++;
            $display("FAIL class_clear_width: got clr %b inv %b expected 0 0",
                     bus.class_clear, bus.invuln);
        end
        release_btn();
    endtask

    task automatic test_boss_win();
        bus.char_class = 2'd2; bus.char_hp = 4'd2;
        press();
        tests_run++;
        if (bus.game_active !== 2'd1 || bus.player_hp !== 4'd2) begin
            tests_failed++;
            $display("FAIL win_start: got state %0d hp %0d expected 1 2",
                     bus.game_active, bus.player_hp);
        end
        release_btn();
        bus.hit = 1'b1; bus.hit_dmg = 4'd2; bus.boss_dead = 1'b1;
        step();
        bus.hit = 1'b0; bus.boss_dead = 1'b0;
        tests_run++;
        if (bus.game_active !== 2'd3 || bus.player_hp !== 4'd0) begin
            tests_failed++;
            $display("FAIL win_priority: got state %0d hp %0d expected 3 0",
                     bus.game_active, bus.player_hp);
        end
        frames(120);
        press();
        tests_run++;
        if (bus.game_active !== 2'd0) begin
            tests_failed++;
            $display("FAIL won_to_menu: got %0d expected 0", bus.game_active);
        end
        release_btn();
    endtask

    task automatic test_reset_in_play();
        int n;
        bus.char_class = 2'd1; bus.char_hp = 4'd10;
        press();
        release_btn();
        bus.hit = 1'b1; bus.hit_dmg = 4'd1;
        step();
        bus.hit = 1'b0;
        tests_run++;
        if (bus.game_active !== 2'd1 || bus.invuln !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_setup: got state %0d inv %b expected 1 1",
                     bus.game_active, bus.invuln);
        end
        bus.mouse_x = 12'd0;
        rst = 1'b1; bus.mouse_left = 1'b1;
        step();
        tests_run++;
        if (bus.game_active !== 2'd0 || bus.player_hp !== 4'd0 || bus.invuln !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_in_play: got state %0d hp %0d inv %b expected 0 0 0",
                     bus.game_active, bus.player_hp, bus.invuln);
        end
        step();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.mouse_clicked === 1'b1) n++;
        end
        tests_run++;
        if (n != 0) begin
            tests_failed++;
            $display("FAIL rst_held_button: got %0d pulses expected 0", n);
        end
        bus.mouse_left = 1'b0;
        repeat (6) step();
        bus.mouse_left = 1'b1;
        repeat (4) step();
        tests_run++;
        if (bus.mouse_clicked !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_next_press: got %b expected 1", bus.mouse_clicked);
        end
        release_btn();
    endtask

    task automatic test_single_pulse();
        int n;
        int first;
        n = 0;
        first = 0;
        bus.mouse_x = 12'd0;
        bus.mouse_left = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            step();
            if (bus.mouse_clicked === 1'b1) begin
                n++;
                if (first == 0) first = i;
            end
        end
        tests_run++;
        if (n != 1) begin
            tests_failed++;
            $display("FAIL pulse_count: got %0d expected 1", n);
        end
        tests_run++;
        if (first != 4) begin
            tests_failed++;
            $display("FAIL pulse_latency: got edge %0d expected 4", first);
        end
        release_btn();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        bus.frame_tick = 1'b0;
        bus.mouse_x = 12'd0;
        bus.mouse_y = 12'd0;
        bus.mouse_left = 1'b0;
        bus.char_class = 2'd0;
        bus.char_hp = 4'd0;
        bus.hit = 1'b0;
        bus.hit_dmg = 4'd0;
        bus.boss_dead = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        test_reset();
        repeat (6) step();
        test_menu();
        test_hits();
        test_end_screen();
        bus.mouse_x = 12'd512; bus.mouse_y = 12'd256;
        test_boss_win();
        bus.mouse_x = 12'd512; bus.mouse_y = 12'd256;
        test_reset_in_play();
        test_single_pulse();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
